// File: rtl/key_bank.sv
// key_bank: multi-channel push-button conditioner.
//
// Every channel is independent: the raw button level is polarity-corrected,
// passed through two synchroniser flops, debounced, and turned into a clean
// level plus single-cycle press, release, long-press and auto-repeat pulses.
//
// Ports:
//   clk         system clock (single domain)
//   rst_n       synchronous active-low reset
//   button      raw asynchronous button levels, one bit per channel
//   key_state   debounced level, 1 = pressed
//   key_down    1-cycle pulse on a debounced press
//   key_up      1-cycle pulse on a debounced release
//   key_long    1-cycle pulse once per press when the hold threshold is reached
//   key_repeat  periodic 1-cycle pulse after key_long while still held
module key_bank #(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int TIME_DELAY   = 16,
  parameter int HOLD_WIDTH   = 24,
  parameter int REPEAT_WIDTH = 22,
  parameter int REPEAT_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] button,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_up,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam logic PRESS_INV = (ACTIVE_LOW != 0);
  localparam logic REPEAT_ON = (REPEAT_EN != 0);
  localparam logic [TIME_DELAY-1:0] DB_ONE   = TIME_DELAY'(1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_t;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      logic                  raw;
      logic                  sync0_reg, sync1_reg;
      logic [TIME_DELAY-1:0] db_cnt_reg, db_cnt_next;
      logic                  key_state_reg, key_state_next;
      logic                  toggle, press_toggle, release_toggle;
      logic                  down_reg, up_reg;
      hold_state_t           state_reg, state_next;
      logic [HOLD_WIDTH-1:0] hold_reg, hold_next;
      logic                  long_reg, long_next;
      logic                  repeat_reg, repeat_next;

      // Internal polarity: 1 = pressed.
      assign raw = button[gi] ^ PRESS_INV;

      // The level flips only after the synced input has disagreed with it for
      // a full counter period; any agreement in between restarts the count.
      assign toggle         = (key_state_reg != sync1_reg) && (&db_cnt_reg);
      assign press_toggle   = toggle && !key_state_reg;
      assign release_toggle = toggle &&  key_state_reg;

      always_comb begin
        db_cnt_next    = db_cnt_reg;
        key_state_next = key_state_reg;
        if (key_state_reg == sync1_reg) begin
          db_cnt_next = '0;
        end else if (&db_cnt_reg) begin
          db_cnt_next    = '0;
          key_state_next = ~key_state_reg;
        end else begin
          db_cnt_next = db_cnt_reg + DB_ONE;
        end
      end

      // Hold/repeat FSM. A release toggle always wins over a terminal count
      // landing on the same edge, so key_up is never paired with long/repeat.
      always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            hold_next = '0;
            if (press_toggle) begin
              state_next = ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (release_toggle) begin
              state_next = ST_IDLE;
              hold_next  = '0;
            end else if (&hold_reg) begin
              long_next  = 1'b1;
              hold_next  = '0;
              state_next = ST_REPEAT;
            end else begin
              hold_next = hold_reg + HOLD_ONE;
            end
          end
          ST_REPEAT: begin
            // Counter restarts from zero here, so only the low bits ever move.
            if (release_toggle) begin
              state_next = ST_IDLE;
              hold_next  = '0;
            end else if (&hold_reg[REPEAT_WIDTH-1:0]) begin
              repeat_next = REPEAT_ON;
              hold_next   = '0;
            end else begin
              hold_next = hold_reg + HOLD_ONE;
            end
          end
          default: begin
            state_next = ST_IDLE;
            hold_next  = '0;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync0_reg     <= 1'b0;
          sync1_reg     <= 1'b0;
          db_cnt_reg    <= '0;
          key_state_reg <= 1'b0;
          down_reg      <= 1'b0;
          up_reg        <= 1'b0;
          state_reg     <= ST_IDLE;
          hold_reg      <= '0;
          long_reg      <= 1'b0;
          repeat_reg    <= 1'b0;
        end else begin
          sync0_reg     <= raw;
          sync1_reg     <= sync0_reg;
          db_cnt_reg    <= db_cnt_next;
          key_state_reg <= key_state_next;
          down_reg      <= press_toggle;
          up_reg        <= release_toggle;
          state_reg     <= state_next;
          hold_reg      <= hold_next;
          long_reg      <= long_next;
          repeat_reg    <= repeat_next;
        end
      end

      assign key_state[gi]  = key_state_reg;
      assign key_down[gi]   = down_reg;
      assign key_up[gi]     = up_reg;
      assign key_long[gi]   = long_reg;
      assign key_repeat[gi] = repeat_reg;
    end
  endgenerate

endmodule

// File: doc/key_bank.md
# key_bank

Parametrised multi-channel key conditioner; the next generation of the single-button debouncer. Each of `N_KEYS` raw button inputs is synchronised, debounced and turned into a level plus one-cycle event pulses: press, release, long-press and auto-repeat. It sits between board push-buttons and the timer control logic, so the controller consumes clean single-cycle events instead of edge-detecting levels itself.

## Interface
- `N_KEYS`, 4: number of independent channels.
- `ACTIVE_LOW`, 1: 1 = raw input reads 0 when pressed; 0 = reads 1 when pressed.
- `TIME_DELAY`, 16: debounce counter width; a level change must persist for 2^TIME_DELAY cycles (about 1.3 ms at 50 MHz for 16).
- `HOLD_WIDTH`, 24: hold counter width; the long-press threshold is 2^HOLD_WIDTH cycles.
- `REPEAT_WIDTH`, 22: repeat period counter width; must be ≤ `HOLD_WIDTH`.
- `REPEAT_EN`, 1: 0 = `key_repeat` is held at 0.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `button`  in  N_KEYS  raw, asynchronous button levels.
- `key_state`  out  N_KEYS  debounced level, 1 = pressed.
- `key_down`  out  N_KEYS  1-cycle pulse on a debounced press.
- `key_up`  out  N_KEYS  1-cycle pulse on a debounced release.
- `key_long`  out  N_KEYS  1-cycle pulse, once per press, when the hold threshold is reached.
- `key_repeat`  out  N_KEYS  periodic 1-cycle pulse after `key_long` while the key stays held.

## Operation
- Channels are fully independent. No priority and no cross-channel interaction.
- Input stage:
  - `button` is XORed with `ACTIVE_LOW`, so internal 1 = pressed.
  - The result passes through 2 flip-flops (`sync0`, `sync1`).
- Debounce:
  - `idle` = (`key_state` == `sync1`).
  - While `idle`, the debounce counter is 0.
  - Otherwise the counter increments. On the edge where it is all-ones, `key_state` toggles and the counter wraps to 0.
  - Any return to `idle` before that point clears the counter, so the glitch is discarded.
- Events are registered on the same edge as the `key_state` toggle:
  - 0→1 toggle: `key_down` = 1.
  - 1→0 toggle: `key_up` = 1.
- Hold/repeat state machine per channel:
  - IDLE: `key_state` = 0; hold counter = 0.
  - HOLD: entered on the press toggle. Hold counter increments each cycle. On the edge where it is all-ones (`HOLD_WIDTH` bits), `key_long` pulses, the counter clears, and the FSM moves to REPEAT.
  - REPEAT: the low `REPEAT_WIDTH` bits of the same counter count. On all-ones, `key_repeat` pulses (if `REPEAT_EN`) and the counter wraps to 0. The FSM stays in REPEAT.
  - A release toggle from any state → IDLE and the counter clears.
- `key_long` fires at most once per press, even with `REPEAT_EN` = 0; the FSM still parks in REPEAT.
- Arithmetic: all counters are unsigned and free-running with natural wrap. No saturation logic is needed beyond the state transitions above.

## Timing
- Reset: while `rst_n` = 0 at a `clk` edge:
  - `sync0`, `sync1`, `key_state`, all pulse outputs and all counters = 0.
  - FSM = IDLE.
  - Reset mid-count discards all progress.
- Press latency: raw change settled before edge E1 → `key_state`/`key_down` high after edge E1 + 2^TIME_DELAY + 1 (2 sync stages + 2^TIME_DELAY count cycles). Release latency is identical.
- Key held at reset release: this is treated as a fresh press, and `key_down` fires after the press latency.
- `key_long`: high for the cycle starting 2^HOLD_WIDTH edges after `key_down` was high.
- `key_repeat`: first pulse 2^REPEAT_WIDTH edges after `key_long`, then every 2^REPEAT_WIDTH cycles.
- Every pulse output is high for exactly 1 cycle.
- Simultaneous events: if the release toggle and the hold/repeat terminal count fall on the same edge, `key_up` fires and `key_long`/`key_repeat` are suppressed; the FSM goes to IDLE.
- `key_down` and `key_up` are never high in the same cycle on one channel.

## Test plan
Bench parameters: TIME_DELAY=3, HOLD_WIDTH=5, REPEAT_WIDTH=3, N_KEYS=4, ACTIVE_LOW=1.
- Reset: hold `rst_n`=0 for 3 cycles with `button`=4'b1111 → all outputs 0. Release reset with no press → outputs stay 0 indefinitely.
- Clean press: `button[0]` 1→0 before edge E1 → `key_state[0]` and `key_down[0]` rise after edge E1+9. `key_down[0]` drops 1 cycle later. Other channels stay 0.
- Bounce: toggle `button[1]` with pulses 1–7 cycles long for 100 cycles, then leave it released → no pulses and `key_state[1]`=0. Then hold `button[1]` low for ≥8 synced cycles → exactly one `key_down[1]`.
- Long press and repeat: hold `button[2]` pressed →
  - `key_long[2]` 32 cycles after `key_down[2]`;
  - `key_repeat[2]` 8, 16 and 24 cycles after `key_long[2]`;
  - release → one `key_up[2]` and no further repeats.
- Boundary: align a release so that its debounce toggle lands on the hold terminal-count edge → `key_up` = 1 and `key_long` = 0 on that cycle. Pulse `rst_n` low mid-hold → no `key_long`, and `key_state` = 0.
- Multi-channel and REPEAT_EN: press all 4 channels on staggered cycles → per-channel latencies are independent and exact. Rerun with `REPEAT_EN`=0 → `key_long` still fires and `key_repeat` stays 0.
